// File: rtl/c4_pkg.sv
// c4_pkg: shared cell codes, status codes, FSM state encoding and board indexing
//   CELL_*      2-bit board cell contents
//   status_e    per-move result status reported by move_dropper
//   state_e     move_dropper FSM states
//   cell_idx    flat cell index of (row, col); row 0 is the bottom row
package c4_pkg;
   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;
   typedef enum logic [2:0] {
      ST_OK        = 3'b000,
      ST_COL_FULL  = 3'b001,
      ST_BAD_MOVE  = 3'b010,
      ST_GAME_OVER = 3'b011,
      ST_TIMEOUT   = 3'b100
   } status_e;
   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_WRITE, S_START, S_WAIT_CHECK, S_REPORT
   } state_e;
   function automatic int cell_idx(input int row, input int col, input int cols);
      return row * cols + col;
   endfunction
endpackage

// File: rtl/board_cell_reader.sv
// board_cell_reader: combinational lookup of one 2-bit cell from the flat board vector
//   board_i  ROWS*COLS*2  flat board, cell (r,c) at bits [2*(r*COLS+c)+:2]
//   row_i    3            row to read
//   col_i    3            column to read
//   cell_o   2            cell contents
module board_cell_reader
   import c4_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 8
) (
   input  logic [ROWS*COLS*2-1:0] board_i,
   input  logic [2:0]             row_i,
   input  logic [2:0]             col_i,
   output logic [1:0]             cell_o
);
   assign cell_o = board_i[2*cell_idx(int'(row_i), int'(col_i), COLS)+:2];
endmodule

// File: rtl/move_dropper.sv
// move_dropper: drops a piece into the lowest empty cell of a column, then runs the
//   win-check handshake with the victory checker and reports a per-move status.
//   Optional feature macro CHECK_TIMEOUT_EN: bounds WAIT_CHECK to TIMEOUT_CYCLES and
//   reports status 100 when the checker does not answer in time.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   new_game                     clear board/game_over/winner (IDLE only)
//   drop_valid/drop_ready        drop request handshake
//   drop_col, drop_player        target column, player code (01/10)
//   board_out                    board register, cell (r,c) at [2*(r*COLS+c)+:2]
//   move_row, move_col           position of the last placed piece
//   check_start                  one-cycle pulse to the victory checker
//   check_done, check_winner     checker answer, sampled in WAIT_CHECK only
//   result_valid, result_status  one-cycle result pulse, status held until next report
//   game_over, winner            sticky game-over flag and latched winner
module move_dropper
   import c4_pkg::*;
#(
   parameter int ROWS           = 8,
   parameter int COLS           = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   new_game,
   input  logic                   drop_valid,
   output logic                   drop_ready,
   input  logic [2:0]             drop_col,
   input  logic [1:0]             drop_player,
   output logic [ROWS*COLS*2-1:0] board_out,
   output logic [2:0]             move_row,
   output logic [2:0]             move_col,
   output logic                   check_start,
   input  logic                   check_done,
   input  logic [1:0]             check_winner,
   output logic                   result_valid,
   output logic [2:0]             result_status,
   output logic                   game_over,
   output logic [1:0]             winner
);
   localparam int BW = ROWS * COLS * 2;

   // row/column ports and counters are 3 bits wide
   if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("move_dropper: unsupported ROWS/COLS/TIMEOUT_CYCLES");
   end

   state_e          state_q, state_d;
   status_e         status_q, status_d;
   logic [BW-1:0]   board_q, board_d;
   logic [2:0]      ctr_q, ctr_d;
   logic [2:0]      col_q, col_d;
   logic [1:0]      player_q, player_d;
   logic [2:0]      move_row_q, move_row_d;
   logic [2:0]      move_col_q, move_col_d;
   logic            game_over_q, game_over_d;
   logic [1:0]      winner_q, winner_d;
   logic [1:0]      scan_cell;
   logic            timeout;

   board_cell_reader #(.ROWS(ROWS), .COLS(COLS)) u_reader (
      .board_i (board_q),
      .row_i   (ctr_q),
      .col_i   (col_q),
      .cell_o  (scan_cell)
   );

`ifdef CHECK_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wait_q;
   always_ff @(posedge clk) begin
      if (rst || state_q != S_WAIT_CHECK) wait_q <= '0;
      else wait_q <= wait_q + 1'b1;
   end
   // true in the TIMEOUT_CYCLES-th WAIT_CHECK cycle
   assign timeout = wait_q == WW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         status_q    <= ST_OK;
         board_q     <= '0;
         ctr_q       <= '0;
         col_q       <= '0;
         player_q    <= CELL_EMPTY;
         move_row_q  <= '0;
         move_col_q  <= '0;
         game_over_q <= 1'b0;
         winner_q    <= CELL_EMPTY;
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         board_q     <= board_d;
         ctr_q       <= ctr_d;
         col_q       <= col_d;
         player_q    <= player_d;
         move_row_q  <= move_row_d;
         move_col_q  <= move_col_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      status_d    = status_q;
      board_d     = board_q;
      ctr_d       = ctr_q;
      col_d       = col_q;
      player_d    = player_q;
      move_row_d  = move_row_q;
      move_col_d  = move_col_q;
      game_over_d = game_over_q;
      winner_d    = winner_q;
      case (state_q)
         S_IDLE: begin
            if (new_game) begin
               board_d     = '0;
               game_over_d = 1'b0;
               winner_d    = CELL_EMPTY;
            end else if (drop_valid) begin
               col_d    = drop_col;
               player_d = drop_player;
               ctr_d    = '0;
               if (int'(drop_col) >= COLS || !(drop_player == CELL_P1 || drop_player == CELL_P2)) begin
                  status_d = ST_BAD_MOVE;
                  state_d  = S_REPORT;
               end else if (game_over_q) begin
                  status_d = ST_GAME_OVER;
                  state_d  = S_REPORT;
               end else begin
                  state_d = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            if (scan_cell == CELL_EMPTY) begin
               state_d = S_WRITE;
            end else if (ctr_q == 3'(ROWS - 1)) begin
               status_d = ST_COL_FULL;
               state_d  = S_REPORT;
            end else begin
               ctr_d = ctr_q + 3'd1;
            end
         end
         S_WRITE: begin
            board_d[2*cell_idx(int'(ctr_q), int'(col_q), COLS)+:2] = player_q;
            move_row_d = ctr_q;
            move_col_d = col_q;
            state_d    = S_START;
         end
         S_START: state_d = S_WAIT_CHECK;
         S_WAIT_CHECK: begin
            if (check_done) begin
               if (check_winner != CELL_EMPTY) begin
                  game_over_d = 1'b1;
                  winner_d    = check_winner;
               end
               status_d = ST_OK;
               state_d  = S_REPORT;
            end else if (timeout) begin
               status_d = ST_TIMEOUT;
               state_d  = S_REPORT;
            end
         end
         S_REPORT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      drop_ready   = (state_q == S_IDLE) && !new_game;
      check_start  = state_q == S_START;
      result_valid = state_q == S_REPORT;
   end

   assign board_out     = board_q;
   assign move_row      = move_row_q;
   assign move_col      = move_col_q;
   assign result_status = status_q;
   assign game_over     = game_over_q;
   assign winner        = winner_q;
endmodule

// File: tb/tb_move_dropper.sv
// tb_move_dropper: table-driven drops with a scoreboard queue plus reset/new_game/timeout sequences
module tb_move_dropper;
   localparam int ROWS = 8;
   localparam int COLS = 7;
   localparam int TO   = 16;
   localparam int BW   = ROWS * COLS * 2;

   logic          clk = 1'b0;
   logic          rst, new_game, drop_valid, drop_ready;
   logic [2:0]    drop_col;
   logic [1:0]    drop_player;
   logic [BW-1:0] board_out;
   logic [2:0]    move_row, move_col;
   logic          check_start, check_done;
   logic [1:0]    check_winner;
   logic          result_valid;
   logic [2:0]    result_status;
   logic          game_over;
   logic [1:0]    winner;

   move_dropper #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .new_game(new_game), .drop_valid(drop_valid), .drop_ready(drop_ready),
      .drop_col(drop_col), .drop_player(drop_player), .board_out(board_out), .move_row(move_row),
      .move_col(move_col), .check_start(check_start), .check_done(check_done),
      .check_winner(check_winner), .result_valid(result_valid), .result_status(result_status),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [1:0] mb [ROWS][COLS];
   logic       m_go = 1'b0;
   logic [1:0] m_win = 2'b00;

   // dly: cycles from check_start to check_done; 0 = checker never answers
   typedef struct {
      logic [2:0] col; logic [1:0] pl; logic [1:0] win; int dly; logic [2:0] st; logic [2:0] row;
   } vec_t;
   typedef struct {
      logic [2:0] st; logic [2:0] row; logic [2:0] col; int starts; int lat;
   } exp_t;
   exp_t sbq[$];
   vec_t tv[17];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] model_board();
      logic [BW-1:0] b = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) b[2*(r*COLS+c)+:2] = mb[r][c];
      return b;
   endfunction

   task automatic clear_model();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) mb[r][c] = 2'b00;
      m_go = 1'b0;
      m_win = 2'b00;
   endtask

   task automatic drop(input vec_t v);
      exp_t e, g;
      int n, starts, t_start, w;
      bit seen;
      e.st = v.st; e.row = v.row; e.col = v.col;
      e.starts = (v.st == 3'b000 || v.st == 3'b100) ? 1 : 0;
      e.lat = (v.st == 3'b000) ? int'(v.row) + 3 + v.dly :
              (v.st == 3'b100) ? int'(v.row) + 3 + TO :
              (v.st == 3'b001) ? ROWS : 0;
      sbq.push_back(e);
      w = 0;
      while (!drop_ready && w < 50) begin @(negedge clk); w++; end
      chk("drop_ready", 128'(drop_ready), 128'(1));
      drop_valid = 1'b1; drop_col = v.col; drop_player = v.pl;
      @(negedge clk);
      drop_valid = 1'b0;
      n = 0; starts = 0; t_start = -1; seen = 0;
      while (!seen && n < 300) begin
         if (result_valid) begin
            seen = 1;
         end else begin
            if (check_start) begin
               starts++;
               t_start = n;
               chk("start_move_row", 128'(move_row), 128'(e.row));
               chk("start_move_col", 128'(move_col), 128'(e.col));
               chk("start_cell", 128'(board_out[2*(int'(e.row)*COLS+int'(e.col))+:2]), 128'(v.pl));
            end
            check_done = t_start >= 0 && v.dly > 0 && n == t_start + v.dly;
            check_winner = check_done ? v.win : 2'b00;
            @(negedge clk);
            n++;
         end
      end
      check_done = 1'b0;
      check_winner = 2'b00;
      g = sbq.pop_front();
      if (!seen) begin
         chk("result_wait_expired", 128'(0), 128'(1));
         return;
      end
      if (g.st == 3'b000 || g.st == 3'b100) mb[g.row][g.col] = v.pl;
      if (g.st == 3'b000 && v.win != 2'b00) begin m_go = 1'b1; m_win = v.win; end
      chk("status", 128'(result_status), 128'(g.st));
      chk("start_pulses", 128'(starts), 128'(g.starts));
      chk("latency", 128'(n), 128'(g.lat));
      chk("board", 128'(board_out), 128'(model_board()));
      chk("game_over", 128'(game_over), 128'(m_go));
      chk("winner", 128'(winner), 128'(m_win));
      if (g.starts == 1) begin
         chk("report_move_row", 128'(move_row), 128'(g.row));
         chk("report_move_col", 128'(move_col), 128'(g.col));
      end
      @(negedge clk);
      chk("result_one_cycle", 128'(result_valid), 128'(0));
      chk("status_held", 128'(result_status), 128'(g.st));
   endtask

   initial begin
      vec_t v;
      int w;
      tv[0]  = '{3'd3, 2'b01, 2'b00, 1, 3'b000, 3'd0};
      tv[1]  = '{3'd5, 2'b01, 2'b00, 1, 3'b000, 3'd0};
      tv[2]  = '{3'd5, 2'b10, 2'b00, 2, 3'b000, 3'd1};
      tv[3]  = '{3'd5, 2'b01, 2'b00, 3, 3'b000, 3'd2};
      tv[4]  = '{3'd5, 2'b10, 2'b00, 1, 3'b000, 3'd3};
      tv[5]  = '{3'd5, 2'b01, 2'b00, 2, 3'b000, 3'd4};
      tv[6]  = '{3'd5, 2'b10, 2'b00, 3, 3'b000, 3'd5};
      tv[7]  = '{3'd5, 2'b01, 2'b00, 1, 3'b000, 3'd6};
      tv[8]  = '{3'd5, 2'b10, 2'b00, 2, 3'b000, 3'd7};
      tv[9]  = '{3'd5, 2'b01, 2'b00, 1, 3'b001, 3'd0};
      tv[10] = '{3'd7, 2'b01, 2'b00, 1, 3'b010, 3'd0};
      tv[11] = '{3'd2, 2'b11, 2'b00, 1, 3'b010, 3'd0};
      tv[12] = '{3'd2, 2'b00, 2'b00, 1, 3'b010, 3'd0};
      tv[13] = '{3'd6, 2'b10, 2'b00, 1, 3'b000, 3'd0};
      tv[14] = '{3'd3, 2'b10, 2'b10, 4, 3'b000, 3'd1};
      tv[15] = '{3'd0, 2'b01, 2'b00, 1, 3'b011, 3'd0};
      tv[16] = '{3'd7, 2'b11, 2'b00, 1, 3'b010, 3'd0};
      clear_model();
      rst = 1'b1; new_game = 1'b0; drop_valid = 1'b0; drop_col = '0; drop_player = '0;
      check_done = 1'b0; check_winner = '0;
      repeat (2) @(negedge clk);
      chk("rst_board", 128'(board_out), 128'(0));
      chk("rst_move", 128'({move_row, move_col}), 128'(0));
      chk("rst_pulses", 128'({check_start, result_valid}), 128'(0));
      chk("rst_status", 128'(result_status), 128'(0));
      chk("rst_game", 128'({game_over, winner}), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 128'(drop_ready), 128'(1));

      for (int i = 0; i < 17; i++) drop(tv[i]);

      // new_game clears board and game-over state without a result pulse
      new_game = 1'b1;
      #1 chk("ng_ready_low", 128'(drop_ready), 128'(0));
      @(negedge clk);
      new_game = 1'b0;
      clear_model();
      chk("ng_board", 128'(board_out), 128'(0));
      chk("ng_game", 128'({game_over, winner}), 128'(0));
      chk("ng_no_result", 128'(result_valid), 128'(0));
      v = '{3'd3, 2'b01, 2'b00, 2, 3'b000, 3'd0};
      drop(v);

      // reset during WAIT_CHECK aborts silently; late check_done ignored
      drop_valid = 1'b1; drop_col = 3'd4; drop_player = 2'b10;
      @(negedge clk);
      drop_valid = 1'b0;
      w = 0;
      while (!check_start && w < 20) begin @(negedge clk); w++; end
      chk("rw_start_seen", 128'(check_start), 128'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      chk("rw_board", 128'(board_out), 128'(0));
      chk("rw_no_result", 128'(result_valid), 128'(0));
      chk("rw_ready", 128'(drop_ready), 128'(1));
      check_done = 1'b1; check_winner = 2'b01;
      @(negedge clk);
      check_done = 1'b0; check_winner = 2'b00;
      for (int k = 0; k < 3; k++) begin
         chk("late_done_quiet", 128'({result_valid, check_start, game_over}), 128'(0));
         @(negedge clk);
      end
      chk("late_done_ready", 128'(drop_ready), 128'(1));

`ifdef CHECK_TIMEOUT_EN
      v = '{3'd1, 2'b01, 2'b00, 0, 3'b100, 3'd0};
`else
      v = '{3'd1, 2'b01, 2'b00, 60, 3'b000, 3'd0};
`endif
      drop(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired expected done");
      $fatal(1, "time limit");
   end
endmodule
